// File: rtl/x3q16_pkg.sv
// Shared x3q16 encodings: ALU mode codes, branch codes and the exwb stall FSM state.
package x3q16_pkg;

    localparam logic [2:0] MODE_ADD  = 3'b000;
    localparam logic [2:0] MODE_SUB  = 3'b001;
    localparam logic [2:0] MODE_MUL  = 3'b010;
    localparam logic [2:0] MODE_NAND = 3'b011;
    localparam logic [2:0] MODE_SHL  = 3'b100;
    localparam logic [2:0] MODE_SHR  = 3'b101;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_GT   = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/x3q16_exwb.sv
// x3q16 execute/writeback stage: one-entry writeback slot, flag register,
// branch resolution and a forwarding tap, with an optional multiply stall.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | normal issue; a multiply spends this cycle settling
//   ST_MUL  | multiply has had its extra cycle, accept when slot is free
module x3q16_exwb
    import x3q16_pkg::*;
#(
    parameter int unsigned MUL_STALL = 1,
    parameter int unsigned REG_AW    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wen,
    input  logic              in_setf,
    input  logic [1:0]        in_br,
    input  logic [15:0]       in_target,
    input  logic [15:0]       alu_result,
    input  logic              alu_eq,
    input  logic              alu_gt,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [REG_AW-1:0] wb_rd,
    output logic [15:0]       wb_data,
    output logic              flag_eq,
    output logic              flag_gt,
    output logic              br_taken,
    output logic [15:0]       br_target,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [15:0]       fwd_data
);

    localparam bit MulStallEn = (MUL_STALL != 0);

    state_t state_q;
    state_t state_d;
    logic   slot_free;
    logic   accept;
    logic   wr_slot;
    logic   br_cond;

    assign slot_free = !wb_valid || wb_ready;
    assign accept    = in_valid && in_ready;
    assign wr_slot   = in_wen && (in_rd != '0);

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && (in_mode == MODE_MUL) && MulStallEn) begin
                    state_d = ST_MUL;
                end else begin
                    in_ready = slot_free;
                end
            end
            ST_MUL: begin
                in_ready = slot_free;
                // A dropped in_valid abandons the multiply rather than wedging here.
                if (!in_valid || slot_free) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Branch condition looks at the flags as they stand before this instruction.
    always_comb begin
        br_cond = 1'b0;
        case (in_br)
            BR_EQ:   br_cond = flag_eq;
            BR_GT:   br_cond = flag_gt;
            BR_JMP:  br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else if (accept && wr_slot) begin
            wb_valid <= 1'b1;
            wb_rd    <= in_rd;
            wb_data  <= alu_result;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_eq <= 1'b0;
            flag_gt <= 1'b0;
        end else if (accept && in_setf) begin
            flag_eq <= alu_eq;
            flag_gt <= alu_gt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_taken  <= 1'b0;
            br_target <= '0;
        end else begin
            br_taken <= accept && br_cond;
            if (accept && br_cond) begin
                br_target <= in_target;
            end
        end
    end

    assign fwd_valid = wb_valid;
    assign fwd_rd    = wb_rd;
    assign fwd_data  = wb_data;

endmodule

// File: doc/x3q16_exwb.md
Name: x3q16_exwb

Overview:
- Execute/writeback stage sitting directly downstream of the x3q16 16-bit combinational ALU.
- Each cycle it samples the ALU result and compare flags for the instruction presented by decode. It registers them into a one-entry writeback slot with valid/ready handshake.
- It maintains the architectural flag register, resolves conditional branches, and exposes a forwarding tap for decode.
- It adds one stall cycle for multiply so the 8x8 multiplier path gets a full extra cycle.

Parameters:
- MUL_STALL, 1, 1 = multiply (mode 3'b010) takes 2 cycles to accept; 0 = single-cycle like other modes.
- REG_AW, 3, register-address width (8 GPRs, r0 reads zero).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle (handshake fires on in_valid & in_ready)
- in_mode  in  3  ALU mode driven to the ALU this cycle
- in_rd  in  REG_AW  destination register
- in_wen  in  1  instruction writes in_rd
- in_setf  in  1  instruction updates flag register
- in_br  in  2  00 none, 01 BEQ, 10 BGT, 11 JMP
- in_target  in  16  branch target address
- alu_result  in  16  ALU result for current operands
- alu_eq  in  1  ALU equal flag
- alu_gt  in  1  ALU greater-a flag
- wb_valid  out  1  writeback slot occupied
- wb_ready  in  1  register file consumes slot
- wb_rd  out  REG_AW  slot destination
- wb_data  out  16  slot data
- flag_eq  out  1  architectural equal flag
- flag_gt  out  1  architectural greater flag
- br_taken  out  1  one-cycle pulse, branch taken
- br_target  out  16  target, valid while br_taken
- fwd_valid  out  1  equals wb_valid
- fwd_rd  out  REG_AW  equals wb_rd
- fwd_data  out  16  equals wb_data

Behaviour:
- Reset (async, rst_n low): state IDLE; wb_valid, wb_rd, wb_data, flag_eq, flag_gt, br_taken, br_target all 0. Any in-flight multiply is abandoned. After release, the first acceptance is possible on the next edge.
- slot_free = !wb_valid | wb_ready.
- FSM states: IDLE, MUL.
  - IDLE: if in_valid & in_mode==010 & MUL_STALL==1, then in_ready=0 and go to MUL. Otherwise in_ready=slot_free.
  - MUL: in_ready=slot_free; on accept go to IDLE. Stay in MUL while !slot_free.
  - If in_valid drops in MUL (protocol violation), return to IDLE without accepting.
- Upstream rule: once in_valid is high, in_valid and all in_* / ALU operands are held stable until the handshake fires.
- On accept (edge where in_valid & in_ready):
  - If in_wen & in_rd!=0: wb_valid<=1, wb_rd<=in_rd, wb_data<=alu_result.
  - Otherwise, if wb_ready, wb_valid<=0.
  - in_wen with in_rd==0 is discarded silently.
- Slot drain: with no accept and wb_ready, wb_valid<=0. wb_rd and wb_data hold their last values.
- Simultaneous drain and accept: the slot is replaced in the same edge, so back-to-back throughput is 1 per cycle for non-multiply ops.
- Flags: on accept with in_setf, flag_eq<=alu_eq and flag_gt<=alu_gt. Flags hold otherwise.
- Branch evaluation uses flag values before the current instruction's update:
  - BEQ taken if flag_eq.
  - BGT taken if flag_gt.
  - JMP always taken.
- On an accepted taken branch: br_taken<=1 and br_target<=in_target for exactly one cycle. Otherwise br_taken<=0.
- A branch carrying in_wen also writes (link-style). Latency: accept to wb_valid/br_taken is 1 cycle.
- Forward outputs are combinational copies of the slot registers.
- No arithmetic in this block. All widths pass through unchanged.

Decomposition:
- Shared package x3q16_pkg holds:
  - ALU mode codes (ADD 000, SUB 001, MUL 010, NAND 011, SHL 100, SHR 101).
  - Branch codes (BR_NONE, BR_EQ, BR_GT, BR_JMP).
  - FSM state enum (IDLE, MUL).
- Single module, no sub-module needed. The ALU is instantiated by the enclosing core, not inside this block.

Test Plan:
- Reset mid-multiply: in_mode=010 held for 1 cycle (state MUL), assert rst_n=0 -> wb_valid=0, flags=0, state IDLE; after release, the same op is accepted 2 cycles later.
- ADD stream: 3 back-to-back ops with rd=1,2,3, alu_result 0x0005/0x0006/0x0007, wb_ready=1 -> in_ready constant 1; wb_data 5,6,7 on consecutive cycles.
- Multiply stall: mode 010, rd=4, alu_result 0x0C00, MUL_STALL=1 -> in_ready 0 then 1, wb_valid one cycle after the second cycle, wb_data=0x0C00. With MUL_STALL=0 -> accepted in 1 cycle.
- Backpressure: wb_ready=0 with slot full, new op valid -> in_ready=0, slot unchanged. Raise wb_ready -> the same edge drains and loads the new op.
- Flags/branch: SUB with setf, alu_eq=1, then BEQ target 0x0040 -> br_taken pulse with br_target=0x0040. BGT right after (flag_gt=0) -> no pulse. JMP -> pulse.
- r0 write: in_wen=1, rd=0, alu_result 0xFFFF -> wb_valid stays 0, fwd_valid 0.
